// File: rtl/tug_of_war_game.sv
// Tug-of-war game core: the human (KEY[0]) pulls the rope right, an LFSR-driven computer
// pulls it left; rope position on LEDR[9:1], per-player 0-7 win score on HEX0/HEX5.
module tug_of_war_game #(
   parameter int TICK_SEL = 15
) (
   input  logic       CLOCK_50,
   input  logic       reset_n,
   input  logic [3:0] KEY,
   input  logic [9:0] SW,
   output logic [9:0] LEDR,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic [6:0] HEX2,
   output logic [6:0] HEX3,
   output logic [6:0] HEX4,
   output logic [6:0] HEX5
);
   // Mask of the divider bits that must all be ones; TICK_SEL=0 gives an empty mask (tick always).
   localparam logic [31:0] TICK_MASK  = (32'd1 << TICK_SEL) - 32'd1;
   localparam logic [8:0]  POS_CENTER = 9'b0_0001_0000;

   logic [31:0] r_div;
   logic [9:0]  r_lfsr;
   logic [2:0]  r_h_sync;
   logic [2:0]  r_c_sync;
   logic [8:0]  r_pos;
   logic [2:0]  r_score_r;
   logic [2:0]  r_score_l;

   logic w_tick;
   logic w_human;
   logic w_cp;
   logic w_r_press;
   logic w_l_press;
   logic w_right_win;
   logic w_left_win;
   logic w_unused;

   assign w_tick      = &(r_div | ~TICK_MASK);
   assign w_human     = ~KEY[0];
   assign w_cp        = (r_lfsr > {1'b0, SW[8:0]});
   // Stage 1 is bit 0; a press is a rising edge seen between stages 2 and 3.
   assign w_r_press   = r_h_sync[1] & ~r_h_sync[2];
   assign w_l_press   = r_c_sync[1] & ~r_c_sync[2];
   assign w_right_win = r_pos[0] & w_r_press & ~w_l_press;
   assign w_left_win  = r_pos[8] & w_l_press & ~w_r_press;
   assign w_unused    = &{1'b0, KEY[3:1]};

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + 32'd1;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_lfsr    <= '0;
         r_h_sync  <= '0;
         r_c_sync  <= '0;
         r_pos     <= POS_CENTER;
         r_score_r <= '0;
         r_score_l <= '0;
      end else if (w_tick) begin
         if (SW[9]) begin
            r_lfsr    <= '0;
            r_h_sync  <= '0;
            r_c_sync  <= '0;
            r_pos     <= POS_CENTER;
            r_score_r <= '0;
            r_score_l <= '0;
         end else begin
            r_lfsr <= {r_lfsr[8:0], ~(r_lfsr[9] ^ r_lfsr[6])};
            if (w_right_win || w_left_win) begin
               r_pos    <= POS_CENTER;
               r_h_sync <= '0;
               r_c_sync <= '0;
               if (w_right_win && (r_score_r != 3'd7)) begin
                  r_score_r <= r_score_r + 3'd1;
               end
               if (w_left_win && (r_score_l != 3'd7)) begin
                  r_score_l <= r_score_l + 3'd1;
               end
            end else begin
               r_h_sync <= {r_h_sync[1:0], w_human};
               r_c_sync <= {r_c_sync[1:0], w_cp};
               if (w_l_press && !w_r_press) begin
                  r_pos <= {r_pos[7:0], 1'b0};
               end else if (w_r_press && !w_l_press) begin
                  r_pos <= {1'b0, r_pos[8:1]};
               end
            end
         end
      end
   end

   function automatic logic [6:0] hex_digit(input logic [2:0] v);
      case (v)
         3'd0:    hex_digit = 7'b1000000;
         3'd1:    hex_digit = 7'b1111001;
         3'd2:    hex_digit = 7'b0100100;
         3'd3:    hex_digit = 7'b0110000;
         3'd4:    hex_digit = 7'b0011001;
         3'd5:    hex_digit = 7'b0010010;
         3'd6:    hex_digit = 7'b0000010;
         default: hex_digit = 7'b1111000;
      endcase
   endfunction

   assign LEDR = {r_pos, 1'b0};
   assign HEX0 = hex_digit(r_score_r);
   assign HEX1 = 7'b1111111;
   assign HEX2 = 7'b1111111;
   assign HEX3 = 7'b1111111;
   assign HEX4 = 7'b1111111;
   assign HEX5 = hex_digit(r_score_l);

endmodule

// File: tb/tb_tug_of_war_game.sv
// Bench for tug_of_war_game (TICK_SEL=0): directed phases drive the buttons, a game model
// queues the expected outputs per cycle, and a monitor pops and compares them.
module tb_tug_of_war_game;

   logic       CLOCK_50 = 1'b0;
   logic       reset_n;
   logic [3:0] KEY;
   logic [9:0] SW;
   logic [9:0] LEDR;
   logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

   // Expected word: {lfsr[61:52], ledr[51:42], hex0[41:35], hex5[34:28], hex4..hex1[27:0]}
   logic [61:0] exp_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   int mon_idx = 0;

   logic [9:0] m_lfsr;
   logic       m_h1, m_h2, m_h3, m_c1, m_c2, m_c3;
   int         m_pos;
   int         m_sr, m_sl, m_lwins;

   always #5 CLOCK_50 = ~CLOCK_50;

   tug_of_war_game #(.TICK_SEL(0)) dut (
      .CLOCK_50 (CLOCK_50),
      .reset_n  (reset_n),
      .KEY      (KEY),
      .SW       (SW),
      .LEDR     (LEDR),
      .HEX0     (HEX0),
      .HEX1     (HEX1),
      .HEX2     (HEX2),
      .HEX3     (HEX3),
      .HEX4     (HEX4),
      .HEX5     (HEX5)
   );

   function automatic logic [6:0] seg(input int v);
      case (v)
         0:       seg = 7'b1000000;
         1:       seg = 7'b1111001;
         2:       seg = 7'b0100100;
         3:       seg = 7'b0110000;
         4:       seg = 7'b0011001;
         5:       seg = 7'b0010010;
         6:       seg = 7'b0000010;
         default: seg = 7'b1111000;
      endcase
   endfunction

   task automatic compare(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
      end
   endtask

   task automatic model_reset();
      m_lfsr = '0;
      {m_h1, m_h2, m_h3, m_c1, m_c2, m_c3} = '0;
      m_pos = 5;
      m_sr = 0;
      m_sl = 0;
   endtask

   // Advances the model as the DUT will at the next rising edge, then queues the result.
   task automatic model_step();
      logic h, cp, r, l;
      logic [9:0] ledr;
      if (!reset_n || SW[9]) begin
         model_reset();
      end else begin
         h  = ~KEY[0];
         cp = (m_lfsr > {1'b0, SW[8:0]});
         r  = m_h2 & ~m_h3;
         l  = m_c2 & ~m_c3;
         m_lfsr = {m_lfsr[8:0], ~(m_lfsr[9] ^ m_lfsr[6])};
         if (r && !l && m_pos == 1) begin
            if (m_sr < 7) m_sr++;
            m_pos = 5;
            {m_h1, m_h2, m_h3, m_c1, m_c2, m_c3} = '0;
         end else if (l && !r && m_pos == 9) begin
            if (m_sl < 7) m_sl++;
            m_lwins++;
            m_pos = 5;
            {m_h1, m_h2, m_h3, m_c1, m_c2, m_c3} = '0;
         end else begin
            m_h3 = m_h2; m_h2 = m_h1; m_h1 = h;
            m_c3 = m_c2; m_c2 = m_c1; m_c1 = cp;
            if (l && !r) m_pos++;
            else if (r && !l) m_pos--;
         end
      end
      ledr = 10'd1 << m_pos;
      exp_q.push_back({m_lfsr, ledr, seg(m_sr), seg(m_sl), {4{7'b1111111}}});
   endtask

   // One clock: drive on the falling edge, queue the expectation, return 2 time units after the rise.
   task automatic cyc(input logic rst, input logic key0, input logic [9:0] sw);
      @(negedge CLOCK_50);
      reset_n = rst;
      KEY     = {3'b111, key0};
      SW      = sw;
      model_step();
      @(posedge CLOCK_50);
      #2;
   endtask

   initial begin : monitor
      logic [61:0] w;
      forever begin
         @(posedge CLOCK_50);
         #1;
         if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            compare($sformatf("c%0d_ledr", mon_idx), 32'(LEDR), 32'(w[51:42]));
            compare($sformatf("c%0d_hex0", mon_idx), 32'(HEX0), 32'(w[41:35]));
            compare($sformatf("c%0d_hex5", mon_idx), 32'(HEX5), 32'(w[34:28]));
            compare($sformatf("c%0d_hex1_4", mon_idx), 32'({HEX4, HEX3, HEX2, HEX1}), 32'(w[27:0]));
            compare($sformatf("c%0d_lfsr", mon_idx), 32'(dut.r_lfsr), 32'(w[61:52]));
            mon_idx++;
         end
      end
   end

   initial begin : stimulus
      logic [9:0] lfsr_tab[5];
      int guard;
      lfsr_tab = '{10'd0, 10'd1, 10'd3, 10'd7, 10'd15};
      reset_n = 1'b0;
      KEY     = 4'hF;
      SW      = 10'h1FF;
      m_lwins = 0;
      model_reset();

      // Reset state and LFSR start sequence
      cyc(1'b0, 1'b1, 10'h1FF);
      cyc(1'b0, 1'b1, 10'h1FF);
      compare("rst_ledr", 32'(LEDR), 32'(10'b0000100000));
      compare("rst_hex0", 32'(HEX0), 32'(7'b1000000));
      compare("rst_hex5", 32'(HEX5), 32'(7'b1000000));
      compare("rst_hex1_4", 32'({HEX4, HEX3, HEX2, HEX1}), 32'(28'hFFFFFFF));
      compare("lfsr_0", 32'(dut.r_lfsr), 32'(lfsr_tab[0]));
      for (int e = 1; e <= 4; e++) begin
         cyc(1'b1, 1'b1, 10'h1FF);
         compare($sformatf("lfsr_%0d", e), 32'(dut.r_lfsr), 32'(lfsr_tab[e]));
      end

      // KEY[0] held for 10 ticks moves the light exactly once
      cyc(1'b0, 1'b1, 10'h1FF);
      cyc(1'b0, 1'b1, 10'h1FF);
      for (int e = 1; e <= 12; e++) begin
         cyc(1'b1, (e <= 10) ? 1'b0 : 1'b1, 10'h1FF);
         if (e == 2)  compare("hold_e2", 32'(LEDR), 32'(10'b0000100000));
         if (e == 3)  compare("hold_e3", 32'(LEDR), 32'(10'b0000010000));
         if (e == 12) compare("hold_e12", 32'(LEDR), 32'(10'b0000010000));
      end

      // Five single-tick presses: four steps to LEDR[1], then a right win
      cyc(1'b0, 1'b1, 10'h1FF);
      cyc(1'b0, 1'b1, 10'h1FF);
      for (int e = 1; e <= 12; e++) begin
         cyc(1'b1, (e <= 9 && (e % 2) == 1) ? 1'b0 : 1'b1, 10'h1FF);
         if (e == 9) compare("press4_ledr", 32'(LEDR), 32'(10'b0000000010));
         if (e == 11) begin
            compare("rwin_hex0", 32'(HEX0), 32'(7'b1111001));
            compare("rwin_ledr", 32'(LEDR), 32'(10'b0000100000));
         end
      end

      // Computer alone with threshold 0: left wins until the score saturates
      guard = 0;
      while (m_lwins < 9 && guard < 50000) begin
         cyc(1'b1, 1'b1, 10'h000);
         guard++;
      end
      if (m_lwins < 9) begin
         n_cmp++;
         n_bad++;
         $display("FAIL left_win_budget got=%0d expected=9", m_lwins);
      end
      compare("lsat_hex5", 32'(HEX5), 32'(7'b1111000));
      compare("lsat_hex0", 32'(HEX0), 32'(7'b1111001));

      // SW[9] new-game clear with both scores nonzero
      cyc(1'b1, 1'b1, 10'h200);
      compare("clr_hex0", 32'(HEX0), 32'(7'b1000000));
      compare("clr_hex5", 32'(HEX5), 32'(7'b1000000));
      compare("clr_ledr", 32'(LEDR), 32'(10'b0000100000));
      compare("clr_lfsr", 32'(dut.r_lfsr), 32'(10'd0));

      // Human and computer presses land on the same tick (4); then a lone human press (tick 9)
      for (int e = 1; e <= 10; e++) begin
         cyc(1'b1, (e == 2 || e == 7) ? 1'b0 : 1'b1, 10'h000);
         if (e == 4) compare("tie_ledr", 32'(LEDR), 32'(10'b0000100000));
         if (e == 9) compare("solo_ledr", 32'(LEDR), 32'(10'b0000010000));
      end

      // Asynchronous reset in the middle of a clock period
      #1;
      reset_n = 1'b0;
      #1;
      compare("async_ledr", 32'(LEDR), 32'(10'b0000100000));
      compare("async_hex0", 32'(HEX0), 32'(7'b1000000));
      compare("async_lfsr", 32'(dut.r_lfsr), 32'(10'd0));
      cyc(1'b0, 1'b1, 10'h000);
      cyc(1'b0, 1'b1, 10'h000);
      for (int e = 1; e <= 3; e++) cyc(1'b1, 1'b1, 10'h000);

      repeat (3) @(posedge CLOCK_50);
      #2;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL queue_drain got=%0d expected=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
